// File: rtl/nco_clk_pkg.sv
// Shared types and helpers for the NCO clock-enable generator.
// Holds the lock FSM state encoding and the increment clamp.
package nco_clk_pkg;

   typedef enum logic [1:0] {
      SETTLE,
      WAIT_APPLY,
      LOCKED
   } lock_state_t;

   localparam logic [31:0] DEFAULT_18M_FROM_50M_INC32 = 32'd1546188227;

   // Rates above refclk/2 are not representable as a strobe, so cap them.
   function automatic logic [63:0] clamp_inc(
      input logic [63:0] value,
      input int          acc_w
   );
      logic [63:0] lim;
      lim = 64'd1 << (acc_w - 1);
      return (value > lim) ? lim : value;
   endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator NCO with a pending increment that is
// applied only at a wrap boundary so the output never glitches.
module nco_channel
   import nco_clk_pkg::*;
#(
   parameter int               ACC_W   = 32,
   parameter logic [ACC_W-1:0] INC_RST = '0
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             we,
   input  logic [ACC_W-1:0] inc,
   output logic             clk_en,
   output logic             clk_sq,
   output logic             pending_valid
);

   localparam logic [ACC_W-1:0] INC_RST_C =
      ACC_W'(clamp_inc(64'(INC_RST), ACC_W));

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_active;
   logic [ACC_W-1:0] pending;
   logic [ACC_W-1:0] wr_inc;
   logic [ACC_W:0]   sum;
   logic             carry;

   assign wr_inc = ACC_W'(clamp_inc(64'(inc), ACC_W));
   assign sum    = {1'b0, acc} + {1'b0, inc_active};
   assign carry  = sum[ACC_W];

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         acc           <= '0;
         inc_active    <= INC_RST_C;
         pending       <= '0;
         pending_valid <= 1'b0;
         clk_en        <= 1'b0;
         clk_sq        <= 1'b0;
      end else begin
         acc    <= sum[ACC_W-1:0];
         clk_en <= carry;
         clk_sq <= sum[ACC_W-1];
         if (we && carry) begin
            inc_active    <= wr_inc;
            pending_valid <= 1'b0;
         end else if (we) begin
            pending       <= wr_inc;
            pending_valid <= 1'b1;
         end else if (pending_valid && (carry || inc_active == '0)) begin
            // a stopped channel never carries, so apply at once
            inc_active    <= pending;
            pending_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/nco_clk_en_gen.sv
// Multi-output NCO clock-enable generator with write decode
// and a lock indicator that waits for all pending updates.
module nco_clk_en_gen
   import nco_clk_pkg::*;
#(
   parameter int NUM_CLOCKS = 2,
   parameter int ACC_W      = 32,
   parameter logic [NUM_CLOCKS*ACC_W-1:0] INC_DEFAULT =
      {NUM_CLOCKS{DEFAULT_18M_FROM_50M_INC32}},
   parameter int LOCK_CYCLES = 16,
   parameter int SEL_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [SEL_W-1:0]      cfg_sel,
   input  logic [ACC_W-1:0]      cfg_inc,
   output logic [NUM_CLOCKS-1:0] clk_en,
   output logic [NUM_CLOCKS-1:0] clk_sq,
   output logic                  locked
);

   localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES);

   logic [NUM_CLOCKS-1:0] we;
   logic [NUM_CLOCKS-1:0] pend;
   logic                  accepted;
   logic                  any_pend;
   lock_state_t           state;
   lock_state_t           state_n;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_n;

   // out-of-range selects match no channel and are dropped
   always_comb begin
      we = '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         we[i] = cfg_we && (cfg_sel == SEL_W'(i));
      end
   end

   assign accepted = |we;
   assign any_pend = |pend;

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
      nco_channel #(
         .ACC_W   (ACC_W),
         .INC_RST (INC_DEFAULT[g*ACC_W +: ACC_W])
      ) u_ch (
         .refclk        (refclk),
         .rst           (rst),
         .we            (we[g]),
         .inc           (cfg_inc),
         .clk_en        (clk_en[g]),
         .clk_sq        (clk_sq[g]),
         .pending_valid (pend[g])
      );
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state  <= SETTLE;
         cnt    <= CNT_LOAD;
         locked <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         locked <= (state_n == LOCKED);
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (accepted) begin
         state_n = SETTLE;
         cnt_n   = CNT_LOAD;
      end else begin
         unique case (state)
            SETTLE: begin
               if (cnt == '0) begin
                  state_n = any_pend ? WAIT_APPLY : LOCKED;
               end else begin
                  cnt_n = cnt - 1'b1;
               end
            end
            WAIT_APPLY: begin
               if (!any_pend) state_n = LOCKED;
            end
            LOCKED: begin
            end
            default: state_n = SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nco_clk_en_gen.sv
// Directed bench for nco_clk_en_gen: ACC_W=8, ch0=64, ch1=96,
// LOCK_CYCLES=5, SEL_W=2 so out-of-range selects can be driven.
module tb_nco_clk_en_gen;

   logic       refclk;
   logic       rst;
   logic       cfg_we;
   logic [1:0] cfg_sel;
   logic [7:0] cfg_inc;
   logic [1:0] clk_en;
   logic [1:0] clk_sq;
   logic       locked;

   int checks = 0;
   int errors = 0;

   logic [31:0] r_en0, r_en1, r_sq0, r_sq1, r_lk;

   nco_clk_en_gen #(
      .NUM_CLOCKS  (2),
      .ACC_W       (8),
      .INC_DEFAULT ({8'd96, 8'd64}),
      .LOCK_CYCLES (5),
      .SEL_W       (2)
   ) dut (
      .refclk  (refclk),
      .rst     (rst),
      .cfg_we  (cfg_we),
      .cfg_sel (cfg_sel),
      .cfg_inc (cfg_inc),
      .clk_en  (clk_en),
      .clk_sq  (clk_sq),
      .locked  (locked)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   task automatic clear_rec();
      r_en0 = '0; r_en1 = '0; r_sq0 = '0; r_sq1 = '0; r_lk = '0;
   endtask

   // edge k after release; inputs set before the call apply at edge k
   task automatic tick(input int k);
      @(posedge refclk);
      @(negedge refclk);
      r_en0[k-1] = clk_en[0];
      r_en1[k-1] = clk_en[1];
      r_sq0[k-1] = clk_sq[0];
      r_sq1[k-1] = clk_sq[1];
      r_lk[k-1]  = locked;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [7:0] v);
      cfg_we  = 1'b1;
      cfg_sel = sel;
      cfg_inc = v;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      cfg_we  = 1'b0;
      cfg_sel = '0;
      cfg_inc = '0;
      repeat (2) @(negedge refclk);
      rst = 1'b1;
      clear_rec();
   endtask

   task automatic test_reset();
      rst = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_inc = '0;
      #1;
      checks++;
      if (clk_en !== 2'b00) begin
         errors++; $display("FAIL reset_en: got %b expected 00", clk_en);
      end
      checks++;
      if (clk_sq !== 2'b00) begin
         errors++; $display("FAIL reset_sq: got %b expected 00", clk_sq);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL reset_lock: got %b expected 0", locked);
      end
   endtask

   task automatic test_default_rates();
      do_reset();
      for (int k = 1; k <= 16; k++) tick(k);
      checks++;
      if (r_en0 !== 32'h8888) begin
         errors++; $display("FAIL def_en0: got %h expected %h", r_en0, 32'h8888);
      end
      checks++;
      if (r_en1 !== 32'hA4A4) begin
         errors++; $display("FAIL def_en1: got %h expected %h", r_en1, 32'hA4A4);
      end
      checks++;
      if (r_sq0 !== 32'h6666) begin
         errors++; $display("FAIL def_sq0: got %h expected %h", r_sq0, 32'h6666);
      end
      checks++;
      if (r_lk !== 32'hFFE0) begin
         errors++; $display("FAIL def_lock: got %h expected %h", r_lk, 32'hFFE0);
      end
   endtask

   task automatic test_glitch_free();
      logic [31:0] w_en0, w_en1, w_lk;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         cfg_we = 1'b0;
         if (k == 11) wr(2'd0, 8'd32);
         tick(k);
      end
      w_en0 = r_en0 >> 10;
      w_en1 = r_en1 >> 10;
      w_lk  = r_lk >> 10;
      checks++;
      if (w_en0 !== 32'h20202) begin
         errors++; $display("FAIL gf_en0: got %h expected %h", w_en0, 32'h20202);
      end
      checks++;
      if (w_en1 !== 32'h92929) begin
         errors++; $display("FAIL gf_en1: got %h expected %h", w_en1, 32'h92929);
      end
      checks++;
      if (w_lk !== 32'hFFFC0) begin
         errors++; $display("FAIL gf_lock: got %h expected %h", w_lk, 32'hFFFC0);
      end
   endtask

   task automatic test_wait_apply();
      do_reset();
      for (int k = 1; k <= 26; k++) begin
         cfg_we = 1'b0;
         if (k == 1) wr(2'd0, 8'd16);
         if (k == 8) wr(2'd0, 8'd64);
         tick(k);
      end
      checks++;
      if (r_lk !== 32'h3F00040) begin
         errors++; $display("FAIL wa_lock: got %h expected %h", r_lk, 32'h3F00040);
      end
      checks++;
      if (r_en0 !== 32'h0880008) begin
         errors++; $display("FAIL wa_en0: got %h expected %h", r_en0, 32'h0880008);
      end
   endtask

   task automatic test_clamp();
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cfg_we = 1'b0;
         if (k == 1) wr(2'd0, 8'd200);
         tick(k);
      end
      checks++;
      if (r_en0 !== 32'hAA8) begin
         errors++; $display("FAIL clamp_en0: got %h expected %h", r_en0, 32'hAA8);
      end
      checks++;
      if (r_sq0 !== 32'h556) begin
         errors++; $display("FAIL clamp_sq0: got %h expected %h", r_sq0, 32'h556);
      end
   endtask

   task automatic test_stop_resume();
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         cfg_we = 1'b0;
         if (k == 1)  wr(2'd1, 8'd0);
         if (k == 10) wr(2'd1, 8'd64);
         tick(k);
      end
      checks++;
      if (r_en1 !== 32'h444004) begin
         errors++; $display("FAIL stop_en1: got %h expected %h", r_en1, 32'h444004);
      end
      checks++;
      if (r_sq1 !== 32'h333002) begin
         errors++; $display("FAIL stop_sq1: got %h expected %h", r_sq1, 32'h333002);
      end
      checks++;
      if (r_lk !== 32'hFF81C0) begin
         errors++; $display("FAIL stop_lock: got %h expected %h", r_lk, 32'hFF81C0);
      end
   endtask

   task automatic test_bad_sel();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         cfg_we = 1'b0;
         if (k == 8) wr(2'd3, 8'd0);
         if (k == 9) wr(2'd2, 8'd32);
         tick(k);
      end
      checks++;
      if (r_en0 !== 32'h8888) begin
         errors++; $display("FAIL sel_en0: got %h expected %h", r_en0, 32'h8888);
      end
      checks++;
      if (r_en1 !== 32'hA4A4) begin
         errors++; $display("FAIL sel_en1: got %h expected %h", r_en1, 32'hA4A4);
      end
      checks++;
      if (r_lk !== 32'hFFE0) begin
         errors++; $display("FAIL sel_lock: got %h expected %h", r_lk, 32'hFFE0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         cfg_we = 1'b0;
         if (k == 1) wr(2'd0, 8'd16);
         if (k == 8) wr(2'd0, 8'd32);
         tick(k);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL ar_wait: got %b expected 0", locked);
      end
      @(posedge refclk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (clk_en !== 2'b00) begin
         errors++; $display("FAIL ar_en: got %b expected 00", clk_en);
      end
      checks++;
      if (clk_sq !== 2'b00) begin
         errors++; $display("FAIL ar_sq: got %b expected 00", clk_sq);
      end
      checks++;
      if (locked !== 1'b0) begin
         errors++; $display("FAIL ar_lock: got %b expected 0", locked);
      end
      @(negedge refclk);
      rst = 1'b1;
      clear_rec();
      for (int k = 1; k <= 16; k++) tick(k);
      checks++;
      if (r_en0 !== 32'h8888) begin
         errors++; $display("FAIL ar_en0: got %h expected %h", r_en0, 32'h8888);
      end
      checks++;
      if (r_en1 !== 32'hA4A4) begin
         errors++; $display("FAIL ar_en1: got %h expected %h", r_en1, 32'hA4A4);
      end
      checks++;
      if (r_lk !== 32'hFFE0) begin
         errors++; $display("FAIL ar_relock: got %h expected %h", r_lk, 32'hFFE0);
      end
   endtask

   initial begin
      test_reset();
      test_default_rates();
      test_glitch_free();
      test_wait_apply();
      test_clamp();
      test_stop_resume();
      test_bad_sel();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
